// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice.
// Contents: default geometry, address-width helper and the default address type.
package regfile_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Address bits needed to index 'depth' entries (at least one bit).
  function automatic int unsigned addr_w(input int unsigned depth);
    if (depth < 2) return 1;
    return $clog2(depth);
  endfunction

  localparam int unsigned DEFAULT_ADDR_W = addr_w(DEFAULT_DEPTH);

  typedef logic [DEFAULT_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the register file.
// Holds the enable/hold data register, the valid flag, the entry-0 mask and,
// when REGFILE_BYPASS_EN is defined, a write-to-read bypass (write-first).
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   re, raddr        read enable and address
//   mem_data         storage contents at raddr (pre-write value)
//   we, waddr, wdata write port snoop (REGFILE_BYPASS_EN builds only)
//   rdata            registered read data, holds when re=0
//   rvalid           1 when rdata was updated on the last edge
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned ZERO_REG0 = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  mem_data,
`ifdef REGFILE_BYPASS_EN
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
`endif
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);

  logic [WIDTH-1:0] rdata_next_c;

  // Select the value to capture; the entry-0 mask overrides the bypass.
  always_comb begin
    rdata_next_c = mem_data;
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr == raddr)) rdata_next_c = wdata;
`endif
    if ((ZERO_REG0 != 0) && (raddr == '0)) rdata_next_c = '0;
  end

  // Output data holds when not enabled; valid pulses for one cycle per read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= rdata_next_c;
    end
  end

endmodule

// File: rtl/register_file.sv
// Parametrised register file: DEPTH words of WIDTH bits, one write port and
// two independent registered read ports (1-cycle latency).
// Optional macro REGFILE_BYPASS_EN: same-edge write data is forwarded to a
// read of the same address (write-first); otherwise reads are read-first.
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   we, waddr, wdata          write port
//   re_a, raddr_a, rdata_a    read port A
//   re_b, raddr_b, rdata_b    read port B
//   rvalid                    bit0 = port A updated last edge, bit1 = port B
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned ZERO_REG0 = 0,
  localparam int unsigned ADDR_W   = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic [1:0]        rvalid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en_c;
  logic [WIDTH-1:0] mem_a_c;
  logic [WIDTH-1:0] mem_b_c;

  // Writes to entry 0 are dropped when it is hardwired to zero.
  assign wr_en_c = we && !((ZERO_REG0 != 0) && (waddr == '0));

  // Storage with asynchronous clear of every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      mem[waddr] <= wdata;
    end
  end

  assign mem_a_c = mem[raddr_a];
  assign mem_b_c = mem[raddr_b];

  regfile_read_port #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .ZERO_REG0 (ZERO_REG0)
  ) u_port_a (
    .clk      (clk),
    .reset    (reset),
    .re       (re_a),
    .raddr    (raddr_a),
    .mem_data (mem_a_c),
`ifdef REGFILE_BYPASS_EN
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .rdata    (rdata_a),
    .rvalid   (rvalid[0])
  );

  regfile_read_port #(
    .WIDTH     (WIDTH),
    .ADDR_W    (ADDR_W),
    .ZERO_REG0 (ZERO_REG0)
  ) u_port_b (
    .clk      (clk),
    .reset    (reset),
    .re       (re_b),
    .raddr    (raddr_b),
    .mem_data (mem_b_c),
`ifdef REGFILE_BYPASS_EN
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .rdata    (rdata_b),
    .rvalid   (rvalid[1])
  );

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised multi-register storage block; the next generation of the single-bit D register with asynchronous clear.
- Holds DEPTH words of WIDTH bits, with one write port and two independent registered read ports.
- Sits between the datapath ALU and its operand sources in lab datapaths.
- Optionally hardwires entry 0 to zero for RISC-style operand use.

Parameters:
- WIDTH, 8, data bits per register (1..32)
- DEPTH, 8, number of registers (power of two, 2..32)
- ADDR_W, $clog2(DEPTH), address bits; derived, do not override
- ZERO_REG0, 0, when 1 entry 0 always reads 0 and ignores writes

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears every register and both read outputs
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a  input  1  read enable, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  registered read data, port A
- re_b  input  1  read enable, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  WIDTH  registered read data, port B
- rvalid  output  2  bit0 = port A data updated last edge, bit1 = port B data updated last edge

Behaviour:
- Reset (asynchronous, active-high):
  - On reset assertion, all DEPTH entries, rdata_a, rdata_b and rvalid go to 0 immediately, without waiting for clk.
  - While reset is high, writes and reads are ignored.
  - The first edge after release behaves normally.
- Write: on a rising edge with we=1, mem[waddr] <= wdata.
  - With ZERO_REG0=1 and waddr=0, the write is dropped.
  - With we=0, storage is unchanged.
- Read: latency is 1 cycle.
  - On a rising edge with re_a=1, rdata_a <= mem[raddr_a] and rvalid[0] <= 1.
  - With re_a=0, rdata_a holds its previous value and rvalid[0] <= 0.
  - Port B is identical, using re_b, raddr_b and rvalid[1].
- Both ports may read the same address in the same cycle; both return the same value.
- Read-during-write to the same address in the same edge, baseline: the read returns the pre-write contents. New data is visible one cycle later.
- ZERO_REG0=1 with read address 0: returns 0 regardless of any write in the same cycle.
- No illegal addresses exist, since DEPTH is a power of two. Address wrap is inherent in ADDR_W.
- No internal FSM. State is DEPTH×WIDTH storage plus 2×WIDTH output registers plus 2 rvalid bits.
- A reset pulse in mid-operation discards any write or read sampled on an edge while reset is high.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: a write-to-read bypass is added on each read port. On an edge with we=1, re_x=1 and raddr_x==waddr (and not the ZERO_REG0 address 0 case), rdata_x <= wdata, giving write-first semantics.
- Undefined: read-first semantics as described in Behaviour. The bypass logic is absent entirely.

Decomposition:
- Shared package regfile_pkg holds:
  - constants DEFAULT_WIDTH=8 and DEFAULT_DEPTH=8
  - a function computing ADDR_W
  - typedef rf_addr_t
- Natural sub-module: regfile_read_port, instantiated twice.
  - It contains the enable/hold output register, rvalid generation, the ZERO_REG0 mask and the optional bypass mux.
- Storage and the write decode stay in the top module.

Test Plan:
1. Reset: preload entries 1..7 with 0xAA, assert reset between clock edges -> all reads of 1..7 return 0x00, rdata_a/b = 0x00 and rvalid = 2'b00 immediately after assertion, before any edge.
2. Write/read: write 0x5C to addr 3, next cycle re_a=1 with raddr_a=3 -> rdata_a = 0x5C one edge later with rvalid[0] = 1. Then drop re_a -> rdata_a stays 0x5C and rvalid[0] = 0.
3. Dual read: addr 2 = 0x11 and addr 6 = 0xF0; same-cycle reads A=2, B=6 -> rdata_a = 0x11, rdata_b = 0xF0, rvalid = 2'b11. Repeat with both ports at 6 -> both return 0xF0.
4. Read-during-write: addr 4 = 0x01; same edge write 0x99 to addr 4 with re_b=1 and raddr_b=4 -> rdata_b = 0x01 without the macro, 0x99 with REGFILE_BYPASS_EN. The following read returns 0x99 in both builds.
5. ZERO_REG0=1: write 0xFF to addr 0, then read addr 0 on both ports -> 0x00, including the same-edge bypass case. With ZERO_REG0=0 the same sequence returns 0xFF.
6. Parameter sweep WIDTH=16, DEPTH=32: write 0xBEEF to addr 31 and 0x1234 to addr 0, then read both -> 0xBEEF and 0x1234. No aliasing between entries.
